// File: rtl/fft_r2sdf_stage.sv
// Radix-2 single-path delay-feedback FFT butterfly stage, LANES complex samples per block.
// Blocks DEPTH apart are combined; sums leave immediately, differences recirculate via the delay line.
module fft_r2sdf_stage #(
   parameter  int DATA_W = 12,
   parameter  int LANES  = 16,
   parameter  int DEPTH  = 2,
   localparam int OUT_W  = DATA_W + 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             din_valid,
   output logic                             din_ready,
   input  logic [LANES-1:0][DATA_W-1:0]     din_r,
   input  logic [LANES-1:0][DATA_W-1:0]     din_i,
   input  logic                             scale_en,
   input  logic                             flush,
   output logic                             dout_valid,
   output logic [LANES-1:0][OUT_W-1:0]      dout_r,
   output logic [LANES-1:0][OUT_W-1:0]      dout_i,
   output logic                             busy
);
   localparam int CNT_W = (2 * DEPTH > 2) ? $clog2(2 * DEPTH) : 1;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(2 * DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_DRAIN} state_t;
   typedef logic [LANES-1:0][OUT_W-1:0] lanes_t;

   state_t           r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next, r_drain_cnt;
   logic             r_pending, w_pending_next;
   logic [PTR_W-1:0] r_ptr;
   lanes_t           r_mem_r [DEPTH];
   lanes_t           r_mem_i [DEPTH];
   lanes_t           w_head_r, w_head_i, w_sum_r, w_sum_i, w_push_r, w_push_i;
   lanes_t           r_dout_r, r_dout_i;
   logic             r_dout_valid;
   logic             w_accept, w_phase_b, w_drain, w_drain_last;

   // Round-half-up halving: floor(x/2) plus the dropped LSB; cannot overflow OUT_W.
   function automatic logic [OUT_W-1:0] scale_round(input logic signed [OUT_W-1:0] x,
                                                    input logic en);
      logic signed [OUT_W-1:0] half;
      half = x >>> 1;
      return en ? half + {{(OUT_W-1){1'b0}}, x[0]} : x;
   endfunction

   assign w_drain      = (r_state == S_DRAIN);
   assign din_ready    = !w_drain;
   assign w_accept     = din_valid && din_ready;
   assign w_phase_b    = (r_cnt >= CNT_HALF);
   assign w_drain_last = w_drain && (r_drain_cnt == HALF_LAST);
   assign w_head_r     = r_mem_r[r_ptr];
   assign w_head_i     = r_mem_i[r_ptr];
   assign busy         = r_pending || w_drain;
   assign dout_valid   = r_dout_valid;
   assign dout_r       = r_dout_r;
   assign dout_i       = r_dout_i;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [OUT_W-1:0] w_a_r, w_a_i, w_b_r, w_b_i;
      assign w_a_r = w_head_r[gi];
      assign w_a_i = w_head_i[gi];
      assign w_b_r = {din_r[gi][DATA_W-1], din_r[gi]};
      assign w_b_i = {din_i[gi][DATA_W-1], din_i[gi]};
      assign w_sum_r[gi]  = scale_round(w_a_r + w_b_r, scale_en);
      assign w_sum_i[gi]  = scale_round(w_a_i + w_b_i, scale_en);
      assign w_push_r[gi] = w_phase_b ? scale_round(w_a_r - w_b_r, scale_en) : w_b_r;
      assign w_push_i[gi] = w_phase_b ? scale_round(w_a_i - w_b_i, scale_en) : w_b_i;
   end

   // Flush is judged on post-acceptance cnt/pending so a wrapping block may start a drain.
   always_comb begin
      w_cnt_next     = r_cnt;
      w_pending_next = r_pending;
      w_state_next   = r_state;
      if (w_accept) begin
         w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         if (r_cnt == CNT_LAST)
            w_pending_next = 1'b1;
         else if (r_pending && r_cnt == HALF_LAST)
            w_pending_next = 1'b0;
      end
      if (w_drain_last)
         w_pending_next = 1'b0;
      case (r_state)
         S_IDLE:  if (flush && w_pending_next && w_cnt_next == '0) w_state_next = S_DRAIN;
         S_DRAIN: if (w_drain_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_pending    <= 1'b0;
         r_drain_cnt  <= '0;
         r_ptr        <= '0;
         r_dout_valid <= 1'b0;
         r_dout_r     <= '0;
         r_dout_i     <= '0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_pending   <= w_pending_next;
         r_drain_cnt <= (w_drain && !w_drain_last) ? r_drain_cnt + 1'b1 : '0;
         if (w_accept || w_drain)
            r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
         r_dout_valid <= 1'b0;
         if (w_accept && w_phase_b) begin
            r_dout_valid <= 1'b1;
            r_dout_r     <= w_sum_r;
            r_dout_i     <= w_sum_i;
         end else if ((w_accept && r_pending) || w_drain) begin
            r_dout_valid <= 1'b1;
            r_dout_r     <= w_head_r;
            r_dout_i     <= w_head_i;
         end
      end
   end

   // Delay line: read and write share one pointer, so each slot is reused exactly DEPTH ops later.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_mem_r[r_ptr] <= w_push_r;
         r_mem_i[r_ptr] <= w_push_i;
      end
   end
endmodule
